// File: rtl/multi_port_regfile.sv
// Multi-port register file: two write ports, one increment port and two
// registered read ports. Updates resolve as clr > write B > write A > increment,
// and reads see the post-update value of the same cycle (write-first).
// A registered flag watches one register against a fixed threshold, and a
// sticky flag records any executed increment that wrapped to zero.
module multi_port_regfile #(
    parameter int          WIDTH   = 16,
    parameter int          DEPTH   = 8,
    parameter int          AW      = $clog2(DEPTH),
    parameter int          CMP_IDX = 1,
    parameter int unsigned POINTS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wea,
    input  logic             web,
    input  logic [AW-1:0]    waa,
    input  logic [AW-1:0]    wab,
    input  logic [WIDTH-1:0] wda,
    input  logic [WIDTH-1:0] wdb,
    input  logic             inc_en,
    input  logic [AW-1:0]    inc_addr,
    input  logic             rea,
    input  logic             reb,
    input  logic [AW-1:0]    raa,
    input  logic [AW-1:0]    rab,
    output logic [WIDTH-1:0] rda,
    output logic [WIDTH-1:0] rdb,
    output logic             rda_valid,
    output logic             rdb_valid,
    output logic             check_all,
    output logic             inc_ovf
);

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] POINTS_W = WIDTH'(POINTS);

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [WIDTH-1:0] rf_d [DEPTH];

    logic [WIDTH-1:0] rda_q, rda_d;
    logic [WIDTH-1:0] rdb_q, rdb_d;
    logic             rda_valid_q, rda_valid_d;
    logic             rdb_valid_q, rdb_valid_d;
    logic             check_all_q, check_all_d;
    logic             inc_ovf_q, inc_ovf_d;

    logic             inc_blocked_s;
    logic             inc_exec_s;
    logic             inc_wrap_s;
    logic [WIDTH-1:0] inc_sum_s;

    // Decide whether the increment survives write collisions and whether it wraps.
    always_comb begin
        inc_blocked_s = (wea && (waa == inc_addr)) || (web && (wab == inc_addr));
        inc_exec_s    = inc_en && !inc_blocked_s && !clr;
        inc_sum_s     = rf_q[inc_addr] + ONE_W;
        inc_wrap_s    = inc_exec_s && (rf_q[inc_addr] == ONES_W);
    end

    // Next value of every register under the clr > B > A > increment priority.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
            if (clr) begin
                rf_d[i] = ZERO_W;
            end else if (web && (wab == AW'(i))) begin
                rf_d[i] = wdb;
            end else if (wea && (waa == AW'(i))) begin
                rf_d[i] = wda;
            end else if (inc_exec_s && (inc_addr == AW'(i))) begin
                rf_d[i] = inc_sum_s;
            end else begin
                rf_d[i] = rf_q[i];
            end
        end
    end

    // Read ports sample the post-update array; flags derive from current state.
    always_comb begin
        rda_d       = rda_q;
        rdb_d       = rdb_q;
        rda_valid_d = rea;
        rdb_valid_d = reb;
        check_all_d = 1'b0;
        inc_ovf_d   = inc_ovf_q;

        if (rea) begin
            rda_d = rf_d[raa];
        end else begin
            rda_d = rda_q;
        end

        if (reb) begin
            rdb_d = rf_d[rab];
        end else begin
            rdb_d = rdb_q;
        end

        if (clr) begin
            check_all_d = 1'b0;
            inc_ovf_d   = 1'b0;
        end else begin
            check_all_d = (rf_q[CMP_IDX] >= POINTS_W);
            inc_ovf_d   = inc_ovf_q | inc_wrap_s;
        end
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= ZERO_W;
            end
            rda_q       <= ZERO_W;
            rdb_q       <= ZERO_W;
            rda_valid_q <= 1'b0;
            rdb_valid_q <= 1'b0;
            check_all_q <= 1'b0;
            inc_ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
            rda_q       <= rda_d;
            rdb_q       <= rdb_d;
            rda_valid_q <= rda_valid_d;
            rdb_valid_q <= rdb_valid_d;
            check_all_q <= check_all_d;
            inc_ovf_q   <= inc_ovf_d;
        end
    end

    assign rda       = rda_q;
    assign rdb       = rdb_q;
    assign rda_valid = rda_valid_q;
    assign rdb_valid = rdb_valid_q;
    assign check_all = check_all_q;
    assign inc_ovf   = inc_ovf_q;

endmodule

// File: tb/tb_multi_port_regfile.sv
// Bench for multi_port_regfile: a hand-computed vector table covering the
// directed corner cases, then randomized traffic checked against a
// behavioural model of the register file.
module tb_multi_port_regfile;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int CMP_IDX = 1;
    localparam int POINTS  = 4;
    localparam int NTBL    = 20;
    localparam int NRND    = 800;

    logic             clk = 1'b0;
    logic             rst, clr, wea, web, inc_en, rea, reb;
    logic [AW-1:0]    waa, wab, inc_addr, raa, rab;
    logic [WIDTH-1:0] wda, wdb;
    logic [WIDTH-1:0] rda, rdb;
    logic             rda_valid, rdb_valid, check_all, inc_ovf;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic             rst;
        logic             clr;
        logic             wea;
        logic [AW-1:0]    waa;
        logic [WIDTH-1:0] wda;
        logic             web;
        logic [AW-1:0]    wab;
        logic [WIDTH-1:0] wdb;
        logic             inc;
        logic [AW-1:0]    ia;
        logic             rea;
        logic [AW-1:0]    raa;
        logic             reb;
        logic [AW-1:0]    rab;
        logic [WIDTH-1:0] e_rda;
        logic             e_rdav;
        logic [WIDTH-1:0] e_rdb;
        logic             e_rdbv;
        logic             e_chk;
        logic             e_ovf;
    } vec_t;

    vec_t tbl [NTBL];

    // Behavioural model state
    logic [WIDTH-1:0] m_rf [DEPTH];
    logic [WIDTH-1:0] m_rda, m_rdb;
    logic             m_rdav, m_rdbv, m_chk, m_ovf;

    multi_port_regfile #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CMP_IDX(CMP_IDX), .POINTS(POINTS)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wea(wea), .web(web), .waa(waa), .wab(wab), .wda(wda), .wdb(wdb),
        .inc_en(inc_en), .inc_addr(inc_addr),
        .rea(rea), .reb(reb), .raa(raa), .rab(rab),
        .rda(rda), .rdb(rdb), .rda_valid(rda_valid), .rdb_valid(rdb_valid),
        .check_all(check_all), .inc_ovf(inc_ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic vec_t mk(int r, int c, int we_a, int a_a, int d_a,
                                int we_b, int a_b, int d_b, int inc, int ia,
                                int re_a, int ra, int re_b, int rb,
                                int xrda, int xrdav, int xrdb, int xrdbv,
                                int xchk, int xovf);
        vec_t v;
        v.rst = 1'(r);      v.clr = 1'(c);
        v.wea = 1'(we_a);   v.waa = AW'(a_a);   v.wda = WIDTH'(d_a);
        v.web = 1'(we_b);   v.wab = AW'(a_b);   v.wdb = WIDTH'(d_b);
        v.inc = 1'(inc);    v.ia  = AW'(ia);
        v.rea = 1'(re_a);   v.raa = AW'(ra);
        v.reb = 1'(re_b);   v.rab = AW'(rb);
        v.e_rda = WIDTH'(xrda); v.e_rdav = 1'(xrdav);
        v.e_rdb = WIDTH'(xrdb); v.e_rdbv = 1'(xrdbv);
        v.e_chk = 1'(xchk);     v.e_ovf  = 1'(xovf);
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [WIDTH-1:0] nrf [DEPTH];
        logic             wrap, kept;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
            m_rda = '0; m_rdb = '0; m_rdav = 1'b0; m_rdbv = 1'b0;
            m_chk = 1'b0; m_ovf = 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
            if (rea) m_rda = '0;
            if (reb) m_rdb = '0;
            m_rdav = rea; m_rdbv = reb;
            m_chk = 1'b0; m_ovf = 1'b0;
        end else begin
            // Lowest priority first, so later writes overwrite earlier ones.
            for (int i = 0; i < DEPTH; i++) nrf[i] = m_rf[i];
            wrap = 1'b0;
            if (inc_en) begin
                nrf[inc_addr] = m_rf[inc_addr] + 16'd1;
                wrap = (m_rf[inc_addr] == 16'hFFFF);
            end
            if (wea) nrf[waa] = wda;
            if (web) nrf[wab] = wdb;
            kept = inc_en && !(wea && waa == inc_addr) && !(web && wab == inc_addr);
            m_ovf = m_ovf | (kept & wrap);
            m_chk = (int'(m_rf[CMP_IDX]) >= POINTS);
            for (int i = 0; i < DEPTH; i++) m_rf[i] = nrf[i];
            if (rea) m_rda = m_rf[raa];
            if (reb) m_rdb = m_rf[rab];
            m_rdav = rea; m_rdbv = reb;
        end
    endtask

    task automatic check(string name, logic [WIDTH-1:0] x_rda, logic x_rdav,
                         logic [WIDTH-1:0] x_rdb, logic x_rdbv, logic x_chk, logic x_ovf);
        n_vec++;
        if (rda !== x_rda || rda_valid !== x_rdav || rdb !== x_rdb ||
            rdb_valid !== x_rdbv || check_all !== x_chk || inc_ovf !== x_ovf) begin
            n_bad++;
            $display("FAIL %s: got rda=%h v=%b rdb=%h v=%b chk=%b ovf=%b, want rda=%h v=%b rdb=%h v=%b chk=%b ovf=%b",
                     name, rda, rda_valid, rdb, rdb_valid, check_all, inc_ovf,
                     x_rda, x_rdav, x_rdb, x_rdbv, x_chk, x_ovf);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; clr = v.clr;
        wea = v.wea; waa = v.waa; wda = v.wda;
        web = v.web; wab = v.wab; wdb = v.wdb;
        inc_en = v.inc; inc_addr = v.ia;
        rea = v.rea; raa = v.raa; reb = v.reb; rab = v.rab;
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1; clr = 1'b0; wea = 1'b0; web = 1'b0; inc_en = 1'b0;
        rea = 1'b0; reb = 1'b0; waa = '0; wab = '0; inc_addr = '0;
        raa = '0; rab = '0; wda = '0; wdb = '0;
        for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
        m_rda = '0; m_rdb = '0; m_rdav = 1'b0; m_rdbv = 1'b0; m_chk = 1'b0; m_ovf = 1'b0;

        //         rst clr wea waa wda     web wab wdb     inc ia rea raa reb rab  rda    v  rdb    v  chk ovf
        tbl[0]  = mk(1, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,  0,     0, 0,     0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 1, 5, 1, 5,  0,     1, 0,     1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 2, 'h1234,  0, 0, 0,       0, 0, 1, 2, 0, 0,  'h1234,1, 0,     0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 3, 'hAAAA,  1, 3, 'h5555,  1, 3, 1, 3, 1, 2,  'h5555,1, 'h1234,1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 1, 3, 0, 0,  'h5555,1, 'h1234,0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 1, 1, 1, 0, 0,  1,     1, 'h1234,0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 1, 1, 1, 0, 0,  2,     1, 'h1234,0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 1, 1, 1, 0, 0,  3,     1, 'h1234,0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 1, 1, 1, 0, 0,  4,     1, 'h1234,0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,  4,     0, 'h1234,0, 1, 0);
        tbl[10] = mk(0, 0, 1, 0, 'hFFFF,  0, 0, 0,       0, 0, 0, 0, 1, 0,  4,     0, 'hFFFF,1, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 1, 0,  4,     0, 0,     1, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 1, 1,  4,     0, 4,     1, 1, 1);
        tbl[13] = mk(0, 1, 1, 1, 'h7777,  0, 0, 0,       1, 1, 1, 1, 1, 3,  0,     1, 0,     1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 1, 3, 1, 1,  0,     1, 0,     1, 0, 0);
        tbl[15] = mk(0, 0, 1, 6, 'hBEEF,  0, 0, 0,       0, 0, 1, 6, 0, 0,  'hBEEF,1, 0,     0, 0, 0);
        tbl[16] = mk(1, 0, 1, 6, 'h1111,  0, 0, 0,       0, 0, 1, 6, 0, 0,  0,     0, 0,     0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 1, 6, 0, 0,  0,     1, 0,     0, 0, 0);
        tbl[18] = mk(0, 0, 1, 5, 'h0099,  1, 2, 'h0042,  1, 2, 1, 2, 1, 5,  'h0042,1, 'h0099,1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 2, 1, 2, 1, 2,  'h0043,1, 'h0043,1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < NTBL; i++) begin
            drive(tbl[i]);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d", i), tbl[i].e_rda, tbl[i].e_rdav, tbl[i].e_rdb,
                  tbl[i].e_rdbv, tbl[i].e_chk, tbl[i].e_ovf);
        end

        for (int i = 0; i < NRND; i++) begin
            rv = '0;
            rv.rst = ($urandom_range(0, 79) == 0);
            rv.clr = ($urandom_range(0, 59) == 0);
            rv.wea = ($urandom_range(0, 2) == 0);
            rv.web = ($urandom_range(0, 3) == 0);
            rv.inc = ($urandom_range(0, 1) == 0);
            rv.rea = ($urandom_range(0, 3) != 0);
            rv.reb = ($urandom_range(0, 3) != 0);
            rv.waa = AW'($urandom_range(0, DEPTH-1));
            rv.wab = AW'($urandom_range(0, DEPTH-1));
            rv.ia  = AW'($urandom_range(0, 3));
            rv.raa = AW'($urandom_range(0, DEPTH-1));
            rv.rab = AW'($urandom_range(0, DEPTH-1));
            case ($urandom_range(0, 3))
                0:       rv.wda = 16'hFFFF;
                1:       rv.wda = WIDTH'($urandom_range(0, 6));
                default: rv.wda = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rv.wdb = 16'hFFFE;
                1:       rv.wdb = WIDTH'($urandom_range(0, 6));
                default: rv.wdb = WIDTH'($urandom);
            endcase
            drive(rv);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d", i), m_rda, m_rdav, m_rdb, m_rdbv, m_chk, m_ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_port_regfile.md
MULTI_PORT_REGFILE -- requirements
Module: multi_port_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each register in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (power of two, >= 4).
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter CMP_IDX, default 1, index of the register watched by the threshold compare.
REQ-005 SHALL have parameter POINTS, default 4, unsigned threshold for the compare.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port clr  input  1  synchronous clear of all registers and flags.
REQ-009 SHALL have ports wea/web  input  1  write enables, port A/B.
REQ-010 SHALL have ports waa/wab  input  AW  write addresses, port A/B.
REQ-011 SHALL have ports wda/wdb  input  WIDTH  write data, port A/B.
REQ-012 SHALL have port inc_en  input  1  increment request.
REQ-013 SHALL have port inc_addr  input  AW  register to increment.
REQ-014 SHALL have ports rea/reb  input  1  read requests, port A/B.
REQ-015 SHALL have ports raa/rab  input  AW  read addresses, port A/B.
REQ-016 SHALL have ports rda/rdb  output  WIDTH  registered read data, port A/B.
REQ-017 SHALL have ports rda_valid/rdb_valid  output  1  read data valid, port A/B.
REQ-018 SHALL have port check_all  output  1  registered flag, RF[CMP_IDX] >= POINTS.
REQ-019 SHALL have port inc_ovf  output  1  sticky increment-overflow flag.

Function
REQ-020 SHALL hold DEPTH registers of WIDTH bits.
REQ-021 SHALL apply updates per cycle, in priority order: rst > clr > write port B > write port A > increment.
REQ-022 SHALL, on clr=1, set all registers to 0, clear inc_ovf and check_all, and ignore writes/increment in that cycle; reads that cycle return 0.
REQ-023 SHALL, on wea=web=1 with waa==wab, write wdb only (port B wins).
REQ-024 SHALL, on inc_en=1, write RF[inc_addr]+1 modulo 2^WIDTH, unless a write port targets inc_addr that cycle (write wins, increment dropped).
REQ-025 SHALL set inc_ovf=1 when an executed increment wraps 2^WIDTH-1 to 0; stays 1 until rst or clr.
REQ-026 SHALL, with rea=1, present rda one cycle later with rda_valid=1; with rea=0, rda holds its previous value and rda_valid=0 (port B identical).
REQ-027 SHALL read write-first: when the read address equals an address updated in the same cycle, the returned value is the post-update value under REQ-021.
REQ-028 SHALL allow both read ports to access any address, including the same one, every cycle.
REQ-029 SHALL update check_all one cycle after RF[CMP_IDX] changes (unsigned compare on the new value).
REQ-030 SHALL sustain one read per port and one update per write/increment source every cycle, with no stalls.

Reset
REQ-031 SHALL, while rst=1 at a rising edge, set all registers, rda, rdb, rda_valid, rdb_valid, check_all and inc_ovf to 0, ignoring all other inputs.
REQ-032 SHALL, with rst asserted mid-operation, drop any in-flight read (valid=0 next cycle) and resume normally the cycle after rst deasserts.

Verification
REQ-033 Reset then rea=1, raa=5 -> next cycle rda=0, rda_valid=1; check_all=0, inc_ovf=0.
REQ-034 wea=1 waa=2 wda=0x1234 and rea=1 raa=2 same cycle -> next cycle rda=0x1234 (bypass).
REQ-035 wea=1 web=1 waa=wab=3 wda=0xAAAA wdb=0x5555 -> RF[3]=0x5555; inc_en on 3 same cycle ignored.
REQ-036 inc_en on addr 1 four times from 0 -> RF[1]=4; check_all rises the cycle after the 4th increment.
REQ-037 wea waa=0 wda=0xFFFF, then inc_en addr 0 -> RF[0]=0, inc_ovf=1; clr -> all registers 0, inc_ovf=0.
REQ-038 rst asserted in cycle after rea=1 -> rda_valid=0, rda=0; first read after deassert valid one cycle later.
